branch_redirect_ctrl: RTL

//   Sequences branch resolution around the EX-stage branch unit. Predicts conditional branches at IF

---
 rtl/branch_pkg.sv | 26 ++
 rtl/bht_table.sv | 31 +++
 rtl/branch_redirect_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch prediction / redirect logic.
// Holds the 2-bit BHT counter encoding and its saturating update rule.
package branch_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  localparam bht_state_e BHT_RESET = WNT;

  // Saturating 2-bit counter step: taken moves toward ST, not-taken toward SNT.
  function automatic bht_state_e bht_next(input bht_state_e state, input logic taken);
    bht_state_e w_next;
    w_next = state;
    if (taken) begin
      if (state != ST) w_next = bht_state_e'(2'(state + 2'd1));
    end else begin
      if (state != SNT) w_next = bht_state_e'(2'(state - 2'd1));
    end
    return w_next;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Direct-mapped branch history table: async read port, sync training port.
// Reads see the pre-update value when the same entry is trained in that cycle.
module bht_table
  import branch_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output bht_state_e       o_rd_state,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  bht_state_e r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= BHT_RESET;
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= bht_next(r_mem[i_wr_idx], i_wr_taken);
    end
  end

  assign o_rd_state = r_mem[i_rd_idx];

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Predicts conditional branches at IF, tracks predictions down to EX and
// raises flush/redirect plus BHT training when EX resolution disagrees.
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned PC_W      = 9,
  parameter int unsigned BHT_IDX_W = 4,
  parameter int unsigned STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic              if_is_branch,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [31:0]       if_imm,
  input  logic              stall,
  input  logic              ex_branch,
  input  logic              ex_pcsel,
  input  logic [31:0]       ex_pc_imm,
  input  logic [31:0]       ex_pc_four,
  input  logic [PC_W-1:0]   ex_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_pc,
  output logic              redirect,
  output logic [31:0]       redirect_pc,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispredict_cnt
);

  logic              r_v_id;
  logic              r_taken_id;
  logic              r_v_ex;
  logic              r_taken_ex;
  logic [STAT_W-1:0] r_branch_cnt;
  logic [STAT_W-1:0] r_mispredict_cnt;

  bht_state_e        w_rd_state;
  logic              w_if_branch;
  logic              w_pred_taken;
  logic              w_resolve;
  logic              w_mispredict;

  bht_table #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_idx   (if_pc[BHT_IDX_W+1:2]),
    .o_rd_state (w_rd_state),
    .i_wr_en    (w_resolve),
    .i_wr_idx   (ex_pc[BHT_IDX_W+1:2]),
    .i_wr_taken (ex_pcsel)
  );

  assign w_if_branch  = if_valid & if_is_branch;
  assign w_pred_taken = w_if_branch & w_rd_state[1];
  // A stalled EX branch is resolved once, in its first unstalled cycle.
  assign w_resolve    = ex_branch & r_v_ex & ~stall;
  assign w_mispredict = w_resolve & (ex_pcsel != r_taken_ex);

  assign pred_taken     = w_pred_taken;
  assign pred_pc        = 32'(if_pc) + if_imm;
  assign redirect       = w_mispredict;
  assign redirect_pc    = ex_pcsel ? ex_pc_imm : ex_pc_four;
  assign flush_ifid     = w_mispredict;
  assign flush_idex     = w_mispredict;
  assign branch_cnt     = r_branch_cnt;
  assign mispredict_cnt = r_mispredict_cnt;

  // Prediction tracking through ID and EX; a mispredict squashes everything younger.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v_id     <= 1'b0;
      r_taken_id <= 1'b0;
      r_v_ex     <= 1'b0;
      r_taken_ex <= 1'b0;
    end else if (w_mispredict) begin
      r_v_id     <= 1'b0;
      r_taken_id <= 1'b0;
      r_v_ex     <= 1'b0;
      r_taken_ex <= 1'b0;
    end else if (!stall) begin
      r_v_ex     <= r_v_id;
      r_taken_ex <= r_taken_id;
      r_v_id     <= w_if_branch;
      r_taken_id <= w_pred_taken;
    end
  end

  // Saturating statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else if (w_resolve) begin
      if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + STAT_W'(1);
      if (w_mispredict && (r_mispredict_cnt != '1))
        r_mispredict_cnt <= r_mispredict_cnt + STAT_W'(1);
    end
  end

endmodule
